// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming(15,11) encode/inject path.
// Codewords are indexed [15:1] so a bit's index is its Hamming position;
// parity lives at positions 1, 2, 4, 8 and data fills the rest in order.
package ham_pkg;

    localparam int HAM_DATA_W = 11;
    localparam int HAM_CODE_W = 15;

    // Galois LFSR feedback mask, applied when the bit shifted out is 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        INJ_NONE  = 2'd0,
        INJ_FIXED = 2'd1,
        INJ_LFSR  = 2'd2,
        INJ_RSVD  = 2'd3
    } inj_mode_e;

    // Codeword position of each data bit; element i is data bit i.
    localparam logic [HAM_DATA_W-1:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    typedef struct packed {
        logic                  injected;
        logic [HAM_CODE_W:1]   ham;
    } ham_entry_t;

    function automatic logic [HAM_CODE_W:1] ham_encode(input logic [HAM_DATA_W-1:0] d);
        logic [HAM_CODE_W:1] c;
        logic                p;
        c = '0;
        for (int i = 0; i < HAM_DATA_W; i++)
            c[DATA_POS[i]] = d[i];
        // A power-of-two position only has its own bit set, so parity slots
        // never feed into each other and the order of k does not matter.
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 1; j <= HAM_CODE_W; j++)
                if (j[k] && (j != (1 << k)))
                    p = p ^ c[j];
            c[1 << k] = p;
        end
        return c;
    endfunction

    // One-hot flip mask for a codeword position; position 0 means no flip.
    function automatic logic [HAM_CODE_W:1] pos_mask(input logic [3:0] pos);
        logic [HAM_CODE_W:1] m;
        m = '0;
        if (pos != 4'd0)
            m[pos] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ham_fifo.sv
// Synchronous FIFO of {injected, ham} entries.
// Ports: clock/reset (sync, active-high); push/wdata write side; pop read
// side; rdata shows the head entry, or the last popped entry when empty
// (cleared by reset); full/empty/count reflect registered occupancy.
// Push while full and pop while empty are ignored.
module ham_fifo
    import ham_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  ham_entry_t    wdata,
    input  logic          pop,
    output ham_entry_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    ham_entry_t    mem [DEPTH];
    ham_entry_t    last_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            if (do_push)
                wptr_q <= wptr_q + AW'(1);
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
                last_q <= mem[rptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: it is only visible while occupied.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wptr_q] <= wdata;
    end

    // When drained, keep presenting the last word rather than stale storage.
    assign rdata = empty ? last_q : mem[rptr_q];

endmodule

// File: rtl/ham_encode_inject.sv
// Hamming(15,11) encoder with optional single-bit error injection, feeding
// a small output FIFO for the downstream corrector.
// Ports: clock/reset (sync, active-high); in_valid/in_ready/in_data input
// handshake; inj_mode/inj_pos sampled with each accepted word;
// out_valid/out_ready/out_ham/out_injected output handshake;
// word_count/inj_count saturating statistics.
module ham_encode_inject
    import ham_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [HAM_DATA_W-1:0] in_data,
    input  logic [1:0]            inj_mode,
    input  logic [3:0]            inj_pos,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HAM_CODE_W:1]   out_ham,
    output logic                  out_injected,
    output logic [15:0]           word_count,
    output logic [15:0]           inj_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    inj_mode_e     mode;
    logic [3:0]    flip_pos;
    logic          flip;
    logic          accept;
    logic [15:0]   lfsr_q;
    logic [15:0]   word_cnt_q, inj_cnt_q;
    ham_entry_t    entry, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    // Ready comes only from registered occupancy (and reset), never from
    // out_ready, so a pop frees space one cycle later.
    assign in_ready = !reset && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign mode     = inj_mode_e'(inj_mode);

    always_comb begin
        flip_pos = 4'd0;
        case (mode)
            INJ_FIXED: flip_pos = inj_pos;
            INJ_LFSR:  flip_pos = lfsr_q[3:0];
            default:   flip_pos = 4'd0;
        endcase
    end

    assign flip           = (flip_pos != 4'd0);
    assign entry.ham      = ham_encode(in_data) ^ pos_mask(flip_pos);
    assign entry.injected = flip;

    // The pre-advance LFSR value picks the flip for this word.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q     <= LFSR_SEED;
            word_cnt_q <= '0;
            inj_cnt_q  <= '0;
        end else if (accept) begin
            if (mode == INJ_LFSR)
                lfsr_q <= lfsr_next(lfsr_q);
            if (word_cnt_q != 16'hFFFF)
                word_cnt_q <= word_cnt_q + 16'd1;
            if (flip && (inj_cnt_q != 16'hFFFF))
                inj_cnt_q <= inj_cnt_q + 16'd1;
        end
    end

    ham_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .wdata (entry),
        .pop   (out_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            assert (fifo_empty == (fifo_count == '0));
    end

    assign out_valid    = !fifo_empty;
    assign out_ham      = head.ham;
    assign out_injected = head.injected;
    assign word_count   = word_cnt_q;
    assign inj_count    = inj_cnt_q;

endmodule
